// File: rtl/y86_decode_execute_stage_if.sv
// Bus bundle for the Y86-64 decode/execute slice.
// Carries the fetched instruction fields into the stage, the register-file
// read data for the instruction held in D, the D and E register contents,
// the ALU result, the branch/cmov condition and the condition codes.
//   slave  : the stage itself (consumes f_* and d_valA/d_valB, drives the rest)
//   master : the surrounding pipeline (fetch, register file, memory stage)
interface y86_decode_execute_stage_if #(
    parameter int WORD = 64
);
    logic [3:0]      f_icode, f_ifun, f_rA, f_rB;
    logic [WORD-1:0] f_valC, f_valP;
    logic            f_hlt, f_in_inst, f_in_mem;

    logic [3:0]      d_icode, d_ifun, d_rA, d_rB;
    logic [WORD-1:0] d_valC, d_valP;
    logic            d_hlt, d_in_inst, d_in_mem;
    logic [WORD-1:0] d_valA, d_valB;

    logic [3:0]      e_icode, e_ifun, e_rA, e_rB;
    logic [WORD-1:0] e_valA, e_valB, e_valC, e_valP;
    logic            e_hlt, e_in_mem, e_in_inst;
    logic [WORD-1:0] e_valE;
    logic            e_cond;

    logic            ZF, SF, OF;

    modport slave (
        input  f_icode, f_ifun, f_rA, f_rB, f_valC, f_valP,
               f_hlt, f_in_inst, f_in_mem, d_valA, d_valB,
        output d_icode, d_ifun, d_rA, d_rB, d_valC, d_valP,
               d_hlt, d_in_inst, d_in_mem,
               e_icode, e_ifun, e_rA, e_rB, e_valA, e_valB, e_valC, e_valP,
               e_hlt, e_in_mem, e_in_inst, e_valE, e_cond, ZF, SF, OF
    );

    modport master (
        output f_icode, f_ifun, f_rA, f_rB, f_valC, f_valP,
               f_hlt, f_in_inst, f_in_mem, d_valA, d_valB,
        input  d_icode, d_ifun, d_rA, d_rB, d_valC, d_valP,
               d_hlt, d_in_inst, d_in_mem,
               e_icode, e_ifun, e_rA, e_rB, e_valA, e_valB, e_valC, e_valP,
               e_hlt, e_in_mem, e_in_inst, e_valE, e_cond, ZF, SF, OF
    );
endinterface

// File: rtl/y86_decode_execute_stage.sv
// Y86-64 pipeline slice: D pipeline register, E pipeline register and the
// execute stage (ALU, condition codes, jXX/cmov condition).
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset (both registers become nop bubbles,
//           CC = {ZF=1, SF=0, OF=0})
//   bus   - slave side of y86_decode_execute_stage_if (fetch fields in,
//           register-file read data in, D/E contents, valE, cond and CC out)
module y86_decode_execute_stage #(
    parameter int         WORD        = 64,
    parameter logic [3:0] RESET_ICODE = 4'h1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    y86_decode_execute_stage_if.slave     bus
);
    typedef struct packed {
        logic [3:0]      icode;
        logic [3:0]      ifun;
        logic [3:0]      rA;
        logic [3:0]      rB;
        logic [WORD-1:0] valC;
        logic [WORD-1:0] valP;
        logic            hlt;
        logic            in_inst;
        logic            in_mem;
    } d_fields_t;

    typedef struct packed {
        d_fields_t       base;
        logic [WORD-1:0] valA;
        logic [WORD-1:0] valB;
    } e_fields_t;

    localparam logic [WORD-1:0] STACK_STEP = WORD'(8);

    d_fields_t       d_reg, d_next;
    e_fields_t       e_reg, e_next;
    logic            zf_reg, sf_reg, of_reg;
    logic [WORD-1:0] val_e;
    logic            of_calc;
    logic            cc_update;
    logic            cond;

    always_comb begin
        d_next.icode   = bus.f_icode;
        d_next.ifun    = bus.f_ifun;
        d_next.rA      = bus.f_rA;
        d_next.rB      = bus.f_rB;
        d_next.valC    = bus.f_valC;
        d_next.valP    = bus.f_valP;
        d_next.hlt     = bus.f_hlt;
        d_next.in_inst = bus.f_in_inst;
        d_next.in_mem  = bus.f_in_mem;
    end

    always_comb begin
        e_next.base = d_reg;
        e_next.valA = bus.d_valA;
        e_next.valB = bus.d_valB;
    end

    // ALU. of_calc is only meaningful for OPq add/sub; it is consumed
    // solely when cc_update is set.
    always_comb begin
        val_e   = '0;
        of_calc = 1'b0;
        case (e_reg.base.icode)
            4'h2:       val_e = e_reg.valA;
            4'h3:       val_e = e_reg.base.valC;
            4'h4, 4'h5: val_e = e_reg.valB + e_reg.base.valC;
            4'h6: begin
                case (e_reg.base.ifun)
                    4'h0: begin
                        val_e   = e_reg.valB + e_reg.valA;
                        of_calc = (e_reg.valA[WORD-1] == e_reg.valB[WORD-1]) &&
                                  (val_e[WORD-1] != e_reg.valA[WORD-1]);
                    end
                    4'h1: begin
                        val_e   = e_reg.valB - e_reg.valA;
                        of_calc = (e_reg.valA[WORD-1] != e_reg.valB[WORD-1]) &&
                                  (val_e[WORD-1] != e_reg.valB[WORD-1]);
                    end
                    4'h2:    val_e = e_reg.valB & e_reg.valA;
                    4'h3:    val_e = e_reg.valB ^ e_reg.valA;
                    default: val_e = '0;
                endcase
            end
            4'h8, 4'hA: val_e = e_reg.valB - STACK_STEP;
            4'h9, 4'hB: val_e = e_reg.valB + STACK_STEP;
            default:    val_e = '0;
        endcase
    end

    // Faulting or halting OPq instructions must not disturb the flags.
    assign cc_update = (e_reg.base.icode == 4'h6) && (e_reg.base.ifun <= 4'h3) &&
                       !(e_reg.base.hlt || e_reg.base.in_mem || e_reg.base.in_inst);

    // Condition uses the registered CC, i.e. flags from an older OPq.
    always_comb begin
        cond = 1'b0;
        if (e_reg.base.icode == 4'h2 || e_reg.base.icode == 4'h7) begin
            case (e_reg.base.ifun)
                4'h0:    cond = 1'b1;
                4'h1:    cond = (sf_reg ^ of_reg) | zf_reg;
                4'h2:    cond = sf_reg ^ of_reg;
                4'h3:    cond = zf_reg;
                4'h4:    cond = !zf_reg;
                4'h5:    cond = !(sf_reg ^ of_reg);
                4'h6:    cond = !(sf_reg ^ of_reg) && !zf_reg;
                default: cond = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_reg            <= '0;
            d_reg.icode      <= RESET_ICODE;
            e_reg            <= '0;
            e_reg.base.icode <= RESET_ICODE;
            zf_reg           <= 1'b1;
            sf_reg           <= 1'b0;
            of_reg           <= 1'b0;
        end else begin
            d_reg <= d_next;
            e_reg <= e_next;
            if (cc_update) begin
                zf_reg <= (val_e == '0);
                sf_reg <= val_e[WORD-1];
                of_reg <= of_calc;
            end
        end
    end

    assign bus.d_icode   = d_reg.icode;
    assign bus.d_ifun    = d_reg.ifun;
    assign bus.d_rA      = d_reg.rA;
    assign bus.d_rB      = d_reg.rB;
    assign bus.d_valC    = d_reg.valC;
    assign bus.d_valP    = d_reg.valP;
    assign bus.d_hlt     = d_reg.hlt;
    assign bus.d_in_inst = d_reg.in_inst;
    assign bus.d_in_mem  = d_reg.in_mem;

    assign bus.e_icode   = e_reg.base.icode;
    assign bus.e_ifun    = e_reg.base.ifun;
    assign bus.e_rA      = e_reg.base.rA;
    assign bus.e_rB      = e_reg.base.rB;
    assign bus.e_valA    = e_reg.valA;
    assign bus.e_valB    = e_reg.valB;
    assign bus.e_valC    = e_reg.base.valC;
    assign bus.e_valP    = e_reg.base.valP;
    assign bus.e_hlt     = e_reg.base.hlt;
    assign bus.e_in_mem  = e_reg.base.in_mem;
    assign bus.e_in_inst = e_reg.base.in_inst;
    assign bus.e_valE    = val_e;
    assign bus.e_cond    = cond;

    assign bus.ZF = zf_reg;
    assign bus.SF = sf_reg;
    assign bus.OF = of_reg;
endmodule

// File: tb/tb_y86_decode_execute_stage.sv
module tb_y86_decode_execute_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    y86_decode_execute_stage_if #(.WORD(64)) bus ();

    y86_decode_execute_stage #(.WORD(64), .RESET_ICODE(4'h1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0]  icode, ifun;
        logic [63:0] val_a, val_b, val_c;
        logic        hlt;
        logic [63:0] exp_val_e;
        logic        exp_cond, exp_zf, exp_sf, exp_of;
    } vec_t;

    typedef struct {
        logic [3:0]  icode, ifun, ra, rb;
        logic [63:0] valc, valp;
        logic        hlt, inst, mem;
        logic [63:0] vala, valb;
    } minst_t;

    localparam int NVEC = 23;
    vec_t vecs [NVEC];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] icode, input logic [3:0] ifun,
                                input logic [63:0] a, input logic [63:0] b,
                                input logic [63:0] c, input logic hlt,
                                input logic [63:0] e, input logic cond,
                                input logic z, input logic s, input logic o);
        vec_t v;
        v.icode = icode; v.ifun = ifun; v.val_a = a; v.val_b = b; v.val_c = c;
        v.hlt = hlt; v.exp_val_e = e; v.exp_cond = cond;
        v.exp_zf = z; v.exp_sf = s; v.exp_of = o;
        return v;
    endfunction

    // Reference model: instruction semantics in plain arithmetic.
    function automatic logic [63:0] ref_val_e(input minst_t m);
        case (m.icode)
            4'h2: return m.vala;
            4'h3: return m.valc;
            4'h4, 4'h5: return m.valb + m.valc;
            4'h6: begin
                if (m.ifun == 0) return m.valb + m.vala;
                if (m.ifun == 1) return m.valb - m.vala;
                if (m.ifun == 2) return m.valb & m.vala;
                if (m.ifun == 3) return m.valb ^ m.vala;
                return 64'd0;
            end
            4'h8, 4'hA: return m.valb - 64'd8;
            4'h9, 4'hB: return m.valb + 64'd8;
            default: return 64'd0;
        endcase
    endfunction

    // Overflow = exact signed result differs from the wrapped 64-bit result.
    function automatic logic ref_of(input minst_t m, input logic [63:0] e);
        logic signed [64:0] exact;
        logic signed [64:0] a, b, r;
        a = $signed({m.vala[63], m.vala});
        b = $signed({m.valb[63], m.valb});
        r = $signed({e[63], e});
        if (m.ifun == 0) exact = b + a;
        else if (m.ifun == 1) exact = b - a;
        else return 1'b0;
        return exact != r;
    endfunction

    function automatic logic ref_cond(input minst_t m, input logic z, input logic s, input logic o);
        logic lt;
        lt = (s != o);
        if (m.icode != 4'h2 && m.icode != 4'h7) return 1'b0;
        case (m.ifun)
            4'h0: return 1'b1;
            4'h1: return lt || z;
            4'h2: return lt;
            4'h3: return z;
            4'h4: return !z;
            4'h5: return !lt;
            4'h6: return !lt && !z;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    task automatic drive_f(input minst_t m);
        bus.f_icode = m.icode; bus.f_ifun = m.ifun; bus.f_rA = m.ra; bus.f_rB = m.rb;
        bus.f_valC = m.valc; bus.f_valP = m.valp;
        bus.f_hlt = m.hlt; bus.f_in_inst = m.inst; bus.f_in_mem = m.mem;
    endtask

    function automatic minst_t nop_inst();
        minst_t m;
        m.icode = 4'h1; m.ifun = 0; m.ra = 0; m.rb = 0; m.valc = 0; m.valp = 0;
        m.hlt = 0; m.inst = 0; m.mem = 0; m.vala = 0; m.valb = 0;
        return m;
    endfunction

    task automatic check_reset(input string tag);
        chk({tag, "_d_icode"}, 64'(bus.d_icode), 64'd1);
        chk({tag, "_d_fields"}, {52'd0, bus.d_ifun, bus.d_rA, bus.d_rB}, 64'd0);
        chk({tag, "_d_vals"}, bus.d_valC | bus.d_valP, 64'd0);
        chk({tag, "_d_flags"}, {61'd0, bus.d_hlt, bus.d_in_inst, bus.d_in_mem}, 64'd0);
        chk({tag, "_e_icode"}, 64'(bus.e_icode), 64'd1);
        chk({tag, "_e_fields"}, {49'd0, bus.e_ifun, bus.e_rA, bus.e_rB,
                                 bus.e_hlt, bus.e_in_inst, bus.e_in_mem}, 64'd0);
        chk({tag, "_e_vals"}, bus.e_valA | bus.e_valB | bus.e_valC | bus.e_valP, 64'd0);
        chk({tag, "_e_valE"}, bus.e_valE, 64'd0);
        chk({tag, "_e_cond"}, 64'(bus.e_cond), 64'd0);
        chk({tag, "_cc"}, {61'd0, bus.ZF, bus.SF, bus.OF}, 64'd4);
    endtask

    // Push one instruction through D and E with bubbles around it.
    task automatic issue(input vec_t v, input int idx);
        minst_t m;
        m = nop_inst();
        m.icode = v.icode; m.ifun = v.ifun; m.valc = v.val_c; m.hlt = v.hlt;
        drive_f(m);
        @(posedge clk); #1;
        drive_f(nop_inst());
        bus.d_valA = v.val_a; bus.d_valB = v.val_b;
        @(posedge clk); #1;
        chk($sformatf("vec%0d_valE", idx), bus.e_valE, v.exp_val_e);
        chk($sformatf("vec%0d_cond", idx), 64'(bus.e_cond), 64'(v.exp_cond));
        chk($sformatf("vec%0d_hlt", idx), 64'(bus.e_hlt), 64'(v.hlt));
        bus.d_valA = 0; bus.d_valB = 0;
        @(posedge clk); #1;
        chk($sformatf("vec%0d_cc", idx), {61'd0, bus.ZF, bus.SF, bus.OF},
            {61'd0, v.exp_zf, v.exp_sf, v.exp_of});
        $display("vec %0d icode=%h ifun=%h valE=%h cond=%0d ZF=%0d SF=%0d OF=%0d",
                 idx, v.icode, v.ifun, v.exp_val_e, v.exp_cond, v.exp_zf, v.exp_sf, v.exp_of);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        minst_t md, me, fin;
        logic   mz, ms, mo;
        logic [63:0] v;

        vecs[0]  = mk(4'h6, 4'h0, 64'd3, 64'd4, 0, 0, 64'd7, 0, 0, 0, 0);
        vecs[1]  = mk(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 0, 0,
                      64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 1, 1);
        vecs[2]  = mk(4'h6, 4'h1, 64'd5, 64'd5, 0, 0, 64'd0, 0, 1, 0, 0);
        vecs[3]  = mk(4'h2, 4'h4, 64'h55, 0, 0, 0, 64'h55, 0, 1, 0, 0);
        vecs[4]  = mk(4'h2, 4'h3, 64'h66, 0, 0, 0, 64'h66, 1, 1, 0, 0);
        vecs[5]  = mk(4'h6, 4'h1, 64'd5, 64'd3, 0, 0, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 1, 0);
        vecs[6]  = mk(4'h7, 4'h2, 0, 0, 0, 0, 64'd0, 1, 0, 1, 0);
        vecs[7]  = mk(4'h7, 4'h3, 0, 0, 0, 0, 64'd0, 0, 0, 1, 0);
        vecs[8]  = mk(4'h7, 4'h0, 0, 0, 0, 0, 64'd0, 1, 0, 1, 0);
        vecs[9]  = mk(4'h7, 4'h7, 0, 0, 0, 0, 64'd0, 0, 0, 1, 0);
        vecs[10] = mk(4'h7, 4'h6, 0, 0, 0, 0, 64'd0, 0, 0, 1, 0);
        vecs[11] = mk(4'h8, 4'h0, 0, 64'h100, 0, 0, 64'hF8, 0, 0, 1, 0);
        vecs[12] = mk(4'hB, 4'h0, 0, 64'h100, 0, 0, 64'h108, 0, 0, 1, 0);
        vecs[13] = mk(4'h4, 4'h0, 0, 64'h100, 64'h10, 0, 64'h110, 0, 0, 1, 0);
        vecs[14] = mk(4'h6, 4'h0, 0, 0, 0, 1, 64'd0, 0, 0, 1, 0);
        vecs[15] = mk(4'h6, 4'h2, 64'hF0, 64'h0F, 0, 0, 64'd0, 0, 1, 0, 0);
        vecs[16] = mk(4'h6, 4'h3, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0,
                      64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 1, 0);
        vecs[17] = mk(4'h6, 4'h5, 64'd1, 64'd1, 0, 0, 64'd0, 0, 0, 1, 0);
        vecs[18] = mk(4'h6, 4'h1, 64'd1, 64'h8000_0000_0000_0000, 0, 0,
                      64'h7FFF_FFFF_FFFF_FFFF, 0, 0, 0, 1);
        vecs[19] = mk(4'h7, 4'h1, 0, 0, 0, 0, 64'd0, 1, 0, 0, 1);
        vecs[20] = mk(4'h3, 4'h0, 0, 0, 64'h1234, 0, 64'h1234, 0, 0, 0, 1);
        vecs[21] = mk(4'h9, 4'h0, 0, 64'h100, 0, 0, 64'h108, 0, 0, 0, 1);
        vecs[22] = mk(4'h7, 4'h5, 0, 0, 0, 0, 64'd0, 0, 0, 0, 1);

        drive_f(nop_inst());
        bus.d_valA = 0; bus.d_valB = 0;

        // Reset asserted between clock edges must act immediately.
        #2 rst_n = 1'b0;
        #1 check_reset("reset_init");
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        // Fetch-to-D one edge, fetch-to-E two edges.
        fin = nop_inst();
        fin.icode = 4'h3; fin.valc = 64'd5;
        drive_f(fin);
        @(posedge clk); #1;
        chk("lat_d_icode", 64'(bus.d_icode), 64'd3);
        drive_f(nop_inst());
        @(posedge clk); #1;
        chk("lat_e_icode", 64'(bus.e_icode), 64'd3);
        chk("lat_e_valE", bus.e_valE, 64'd5);

        for (int i = 0; i < NVEC; i++) issue(vecs[i], i);

        // Mid-operation reset: CC currently holds OF=1 from the sub overflow.
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_reset("reset_mid");
        @(negedge clk) rst_n = 1'b1;

        md = nop_inst(); me = nop_inst();
        mz = 1'b1; ms = 1'b0; mo = 1'b0;

        for (int cyc = 0; cyc < 400; cyc++) begin
            int r;
            fin = nop_inst();
            r = $urandom_range(0, 15);
            if (r < 5)       fin.icode = 4'h6;
            else if (r < 8)  fin.icode = 4'h7;
            else if (r < 10) fin.icode = 4'h2;
            else             fin.icode = 4'($urandom_range(0, 15));
            fin.ifun = 4'($urandom_range(0, 7));
            if (fin.icode == 4'h6 && $urandom_range(0, 3) != 0)
                fin.ifun = 4'($urandom_range(0, 3));
            fin.ra = 4'($urandom_range(0, 15));
            fin.rb = 4'($urandom_range(0, 15));
            fin.valc = rand64();
            fin.valp = rand64();
            fin.hlt  = ($urandom_range(0, 19) == 0);
            fin.inst = ($urandom_range(0, 19) == 0);
            fin.mem  = ($urandom_range(0, 19) == 0);
            fin.vala = rand64();
            fin.valb = ($urandom_range(0, 3) == 0) ? fin.vala : rand64();
            if ($urandom_range(0, 7) == 0) fin.vala[63:62] = 2'b01;
            drive_f(fin);
            bus.d_valA = fin.vala; bus.d_valB = fin.valb;

            @(posedge clk);
            if (me.icode == 4'h6 && me.ifun <= 4'h3 && !me.hlt && !me.inst && !me.mem) begin
                v  = ref_val_e(me);
                mz = (v == 64'd0);
                ms = v[63];
                mo = ref_of(me, v);
            end
            me = md;
            me.vala = fin.vala; me.valb = fin.valb;
            md = fin;

            #1;
            chk($sformatf("rnd%0d_d_fields", cyc),
                {45'd0, bus.d_icode, bus.d_ifun, bus.d_rA, bus.d_rB, bus.d_hlt, bus.d_in_inst, bus.d_in_mem},
                {45'd0, md.icode, md.ifun, md.ra, md.rb, md.hlt, md.inst, md.mem});
            chk($sformatf("rnd%0d_d_valC", cyc), bus.d_valC, md.valc);
            chk($sformatf("rnd%0d_d_valP", cyc), bus.d_valP, md.valp);
            chk($sformatf("rnd%0d_e_fields", cyc),
                {45'd0, bus.e_icode, bus.e_ifun, bus.e_rA, bus.e_rB, bus.e_hlt, bus.e_in_inst, bus.e_in_mem},
                {45'd0, me.icode, me.ifun, me.ra, me.rb, me.hlt, me.inst, me.mem});
            chk($sformatf("rnd%0d_e_valA", cyc), bus.e_valA, me.vala);
            chk($sformatf("rnd%0d_e_valB", cyc), bus.e_valB, me.valb);
            chk($sformatf("rnd%0d_e_valC", cyc), bus.e_valC, me.valc);
            chk($sformatf("rnd%0d_e_valP", cyc), bus.e_valP, me.valp);
            chk($sformatf("rnd%0d_e_valE", cyc), bus.e_valE, ref_val_e(me));
            chk($sformatf("rnd%0d_e_cond", cyc), 64'(bus.e_cond), 64'(ref_cond(me, mz, ms, mo)));
            chk($sformatf("rnd%0d_cc", cyc), {61'd0, bus.ZF, bus.SF, bus.OF}, {61'd0, mz, ms, mo});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
